// File: rtl/l1_line_server.sv
// Line-granular backing store answering the L1 request/done protocol: one 8-word line per
// transaction, one word per cycle after LATENCY idle cycles. Optional counters: L1_LINE_SERVER_STATS_EN.
`timescale 1ns/1ps

module l1_line_server #(
   parameter int LINES   = 256,
   parameter int LATENCY = 4
) (
   input  logic         sys_clk,
   input  logic         rst_n,
   input  logic         req_read,
   input  logic         req_write,
   input  logic [31:0]  req_addr,
   input  logic [255:0] req_write_data,
   output logic         done,
   output logic [255:0] read_data,
   output logic         busy
`ifdef L1_LINE_SERVER_STATS_EN
   ,
   output logic [31:0]  rd_count,
   output logic [31:0]  wr_count
`endif
);

   localparam int IDX_W  = $clog2(LINES);
   localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_BEAT,
      ST_DONE
   } state_t;

   state_t             state;
   logic               op_write;
   logic [IDX_W-1:0]   line_idx;
   logic [255:0]       wdata;
   logic [2:0]         beat;
   logic [WAIT_W-1:0]  wait_cnt;

   logic [31:0] mem [LINES*8];

   // Address bits outside the line index carry no meaning here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[31:IDX_W+5], req_addr[4:0]};

   // Storage has no reset; a reset mid-write simply stops further beats.
   always_ff @(posedge sys_clk) begin
      if (state == ST_BEAT && op_write)
         mem[{line_idx, beat}] <= wdata[{beat, 5'b0} +: 32];
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         op_write  <= 1'b0;
         line_idx  <= '0;
         wdata     <= '0;
         beat      <= '0;
         wait_cnt  <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         read_data <= '0;
`ifdef L1_LINE_SERVER_STATS_EN
         rd_count  <= '0;
         wr_count  <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A write wins when both requests are raised together.
               if (req_write || req_read) begin
                  op_write <= req_write;
                  line_idx <= req_addr[IDX_W+4:5];
                  wdata    <= req_write_data;
                  beat     <= '0;
                  wait_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= (LATENCY == 0) ? ST_BEAT : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == WAIT_LAST)
                  state <= ST_BEAT;
               else
                  wait_cnt <= wait_cnt + 1'b1;
            end
            ST_BEAT: begin
               if (!op_write)
                  read_data[{beat, 5'b0} +: 32] <= mem[{line_idx, beat}];
               if (beat == 3'd7) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
`ifdef L1_LINE_SERVER_STATS_EN
                  if (op_write)
                     wr_count <= wr_count + 32'd1;
                  else
                     rd_count <= rd_count + 32'd1;
`endif
               end else begin
                  beat <= beat + 3'd1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
